// File: rtl/multi_clk_div.sv
// Multi-channel programmable 50%-duty clock divider with glitch-free half-period reload.
// Optional TICK_OUT_EN adds a registered one-cycle tick per channel on every clk_out toggle.
module multi_clk_div #(
   parameter int               N_CH        = 2,
   parameter int               CNT_W       = 26,
   parameter logic [CNT_W-1:0] DIV_DEFAULT = CNT_W'(2500000)
) (
   input  logic             clkin,
   input  logic             rst,
   input  logic [N_CH-1:0]  en,
   input  logic             load,
   input  logic [2:0]       load_ch,
   input  logic [CNT_W-1:0] load_val,
   output logic [N_CH-1:0]  clk_out
`ifdef TICK_OUT_EN
   ,
   output logic [N_CH-1:0]  tick
`endif
);

   // Out-of-range load_ch never matches any channel, so such loads are dropped.
   logic [N_CH-1:0] load_sel;

   always_comb begin
      load_sel = '0;
      for (int c = 0; c < N_CH; c++) begin
         load_sel[c] = load && (load_ch == 3'(c));
      end
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      logic [CNT_W-1:0] count;
      logic [CNT_W-1:0] active_h;
      logic [CNT_W-1:0] shadow_h;
      logic             clk_r;
      logic             term;

      assign term = (count == active_h);

      // active_h only changes at a toggle so the running half-period always finishes with its own H.
      always_ff @(posedge clkin) begin
         if (rst) begin
            count    <= '0;
            clk_r    <= 1'b0;
            active_h <= DIV_DEFAULT;
            shadow_h <= DIV_DEFAULT;
         end else begin
            if (en[c]) begin
               if (term) begin
                  clk_r    <= ~clk_r;
                  count    <= '0;
                  active_h <= load_sel[c] ? load_val : shadow_h;
               end else begin
                  count <= count + CNT_W'(1);
               end
            end
            if (load_sel[c]) begin
               shadow_h <= load_val;
            end
         end
      end

      assign clk_out[c] = clk_r;

`ifdef TICK_OUT_EN
      logic tick_r;

      always_ff @(posedge clkin) begin
         if (rst) begin
            tick_r <= 1'b0;
         end else begin
            tick_r <= en[c] && term;
         end
      end

      assign tick[c] = tick_r;
`endif
   end

endmodule

// File: tb/tb_multi_clk_div.sv
// Self-checking bench for multi_clk_div: reset vector table, directed corner sequences,
// and randomized traffic against a remaining-cycles reference model.
module tb_multi_clk_div;
   localparam int N_CH = 2;
   localparam int CNT_W = 8;
   localparam int DEF = 3;

   logic             clkin = 1'b0;
   logic             rst;
   logic [N_CH-1:0]  en;
   logic             load;
   logic [2:0]       load_ch;
   logic [CNT_W-1:0] load_val;
   logic [N_CH-1:0]  clk_out;
   logic [N_CH-1:0]  tick;

   multi_clk_div #(.N_CH(N_CH), .CNT_W(CNT_W), .DIV_DEFAULT(8'd3)) dut (
      .clkin(clkin),
      .rst(rst),
      .en(en),
      .load(load),
      .load_ch(load_ch),
      .load_val(load_val),
      .clk_out(clk_out)
`ifdef TICK_OUT_EN
      ,
      .tick(tick)
`endif
   );

   always #5 clkin = ~clkin;

   int checks = 0;
   int errors = 0;

   // Reference model: cycles remaining in the current half-period plus the pending divisor.
   int       rem [N_CH];
   int       pend[N_CH];
   logic [N_CH-1:0] m_clk;
   logic [N_CH-1:0] m_tick;

   task automatic model_step(input logic r, input logic [1:0] e, input logic l,
                             input logic [2:0] ch, input logic [7:0] v);
      for (int c = 0; c < N_CH; c++) begin
         bit hit;
         hit = l && (int'(ch) == c);
         if (r) begin
            rem[c]    = DEF + 1;
            pend[c]   = DEF;
            m_clk[c]  = 1'b0;
            m_tick[c] = 1'b0;
         end else begin
            if (hit) pend[c] = int'(v);
            if (e[c]) begin
               rem[c] = rem[c] - 1;
               if (rem[c] == 0) begin
                  m_clk[c]  = ~m_clk[c];
                  m_tick[c] = 1'b1;
                  rem[c]    = pend[c] + 1;
               end else begin
                  m_tick[c] = 1'b0;
               end
            end else begin
               m_tick[c] = 1'b0;
            end
         end
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle(input logic r, input logic [1:0] e, input logic l,
                        input logic [2:0] ch, input logic [7:0] v);
      rst = r; en = e; load = l; load_ch = ch; load_val = v;
      @(posedge clkin);
      model_step(r, e, l, ch, v);
      #1;
      checks++;
      if (clk_out !== m_clk) begin
         errors++;
         $display("FAIL model_clk_out actual=%b required=%b t=%0t", clk_out, m_clk, $time);
      end
`ifdef TICK_OUT_EN
      checks++;
      if (tick !== m_tick) begin
         errors++;
         $display("FAIL model_tick actual=%b required=%b t=%0t", tick, m_tick, $time);
      end
`endif
   endtask

   // Runs enabled cycles until channel ch toggles; checks the number of edges it took.
   task automatic wait_toggle(input string name, input int ch, input logic [1:0] e, input int exp);
      logic prev;
      int   n;
      bit   found;
      prev = clk_out[ch];
      n = 0;
      found = 0;
      while (!found && n < 64) begin
         cycle(1'b0, e, 1'b0, 3'd0, 8'd0);
         n++;
         if (clk_out[ch] !== prev) found = 1;
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL %s timeout actual=none required=%0d", name, exp);
      end else begin
         chk(name, n, exp);
      end
   endtask

   task automatic do_reset();
      cycle(1'b1, 2'b00, 1'b0, 3'd0, 8'd0);
      cycle(1'b1, 2'b00, 1'b0, 3'd0, 8'd0);
   endtask

   typedef struct {
      logic       rst;
      logic [1:0] en;
      logic       load;
      logic [2:0] ch;
      logic [7:0] val;
      logic [1:0] exp_clk;
      logic [1:0] exp_tick;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int k;
      int t0, t1;
      logic [1:0] prev;

      vecs[0] = '{1'b1, 2'b00, 1'b0, 3'd0, 8'd0, 2'b00, 2'b00};
      vecs[1] = '{1'b1, 2'b11, 1'b0, 3'd0, 8'd0, 2'b00, 2'b00};
      vecs[2] = '{1'b0, 2'b11, 1'b0, 3'd0, 8'd0, 2'b00, 2'b00};
      vecs[3] = '{1'b0, 2'b11, 1'b0, 3'd0, 8'd0, 2'b00, 2'b00};
      vecs[4] = '{1'b0, 2'b11, 1'b0, 3'd0, 8'd0, 2'b00, 2'b00};
      vecs[5] = '{1'b0, 2'b11, 1'b0, 3'd0, 8'd0, 2'b11, 2'b11};
      vecs[6] = '{1'b0, 2'b11, 1'b0, 3'd0, 8'd0, 2'b11, 2'b00};
      vecs[7] = '{1'b0, 2'b11, 1'b0, 3'd0, 8'd0, 2'b11, 2'b00};
      vecs[8] = '{1'b0, 2'b11, 1'b0, 3'd0, 8'd0, 2'b11, 2'b00};
      vecs[9] = '{1'b0, 2'b11, 1'b0, 3'd0, 8'd0, 2'b00, 2'b11};

      rst = 1'b1; en = '0; load = 1'b0; load_ch = '0; load_val = '0;

      // Reset and default period from the table.
      for (int i = 0; i < 10; i++) begin
         cycle(vecs[i].rst, vecs[i].en, vecs[i].load, vecs[i].ch, vecs[i].val);
         chk($sformatf("vec%0d_clk", i), int'(clk_out), int'(vecs[i].exp_clk));
`ifdef TICK_OUT_EN
         chk($sformatf("vec%0d_tick", i), int'(tick), int'(vecs[i].exp_tick));
`endif
      end

      // Load mid-period: the running half-period keeps the old H.
      do_reset();
      repeat (4) cycle(1'b0, 2'b11, 1'b0, 3'd0, 8'd0);
      chk("load_pre_clk0", int'(clk_out[0]), 1);
      cycle(1'b0, 2'b11, 1'b1, 3'd0, 8'd1);
      wait_toggle("load_cur_half", 0, 2'b11, 3);
      wait_toggle("load_new_half_a", 0, 2'b11, 2);
      wait_toggle("load_new_half_b", 0, 2'b11, 2);
      wait_toggle("load_ch1_unaffected", 1, 2'b11, 4 - ((k = 0)));

      // Coincident load and toggle event.
      k = 0;
      while (rem[0] != 1 && k < 20) begin
         cycle(1'b0, 2'b11, 1'b0, 3'd0, 8'd0);
         k++;
      end
      prev = clk_out;
      cycle(1'b0, 2'b11, 1'b1, 3'd0, 8'd0);
      chk("coinc_toggle", int'(clk_out[0] != prev[0]), 1);
      wait_toggle("coinc_next_a", 0, 2'b11, 1);
      wait_toggle("coinc_next_b", 0, 2'b11, 1);

      // Enable gating on ch1 stretches the half-period by the gated cycles.
      do_reset();
      repeat (2) cycle(1'b0, 2'b11, 1'b0, 3'd0, 8'd0);
      repeat (5) begin
         cycle(1'b0, 2'b01, 1'b0, 3'd0, 8'd0);
         chk("gate_hold_clk1", int'(clk_out[1]), 0);
`ifdef TICK_OUT_EN
         chk("gate_tick1", int'(tick[1]), 0);
`endif
      end
      wait_toggle("gate_stretch", 1, 2'b11, 2);

      // Invalid channel load is ignored.
      do_reset();
      t0 = 0; t1 = 0;
      prev = clk_out;
      cycle(1'b0, 2'b11, 1'b1, 3'd5, 8'd0);
      for (int i = 0; i < 32; i++) begin
         if (i > 0) cycle(1'b0, 2'b11, 1'b0, 3'd0, 8'd0);
         if (clk_out[0] != prev[0]) t0++;
         if (clk_out[1] != prev[1]) t1++;
         prev = clk_out;
      end
      chk("invalid_ch0_toggles", t0, 8);
      chk("invalid_ch1_toggles", t1, 8);

      // Reset mid-operation reverts the divisor.
      do_reset();
      cycle(1'b0, 2'b11, 1'b0, 3'd0, 8'd0);
      cycle(1'b0, 2'b11, 1'b1, 3'd0, 8'd1);
      repeat (3) cycle(1'b0, 2'b11, 1'b0, 3'd0, 8'd0);
      chk("rstmid_pre_clk0", int'(clk_out[0]), 1);
      cycle(1'b1, 2'b11, 1'b0, 3'd0, 8'd0);
      chk("rstmid_clk", int'(clk_out), 0);
      wait_toggle("rstmid_half_a", 0, 2'b11, 4);
      wait_toggle("rstmid_half_b", 0, 2'b11, 4);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         cycle(1'($urandom_range(0, 199) == 0), 2'($urandom), 1'($urandom_range(0, 3) == 0),
               3'($urandom_range(0, 7)), 8'($urandom_range(0, 6)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
